// File: rtl/ahb_lite_sram_responder_if.sv
// rtl/ahb_lite_sram_responder_if.sv - AHB-Lite bus bundle between a master and the SRAM responder
interface ahb_lite_sram_responder_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_responder.sv
// rtl/ahb_lite_sram_responder.sv - AHB-Lite SRAM slave with wait states; AHB_SRAM_ZERO_INIT_EN adds a post-reset clear sweep
module ahb_lite_sram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input logic                        HCLK,
    input logic                        HRESETn,
    ahb_lite_sram_responder_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2,
        ST_CLEAR
    } state_t;

`ifdef AHB_SRAM_ZERO_INIT_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic [ADDR_BITS-1:0] CLR_ONE = 1;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t               state_q, state_d;
    state_t               beat_state;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS+1:0] addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic                 write_q, write_d;
`ifdef AHB_SRAM_ZERO_INIT_EN
    logic [ADDR_BITS-1:0] clr_q, clr_d;
`endif

    logic [31:0]          mem_q [DEPTH];

    logic                 accept;
    logic                 req_err;
    logic [3:0]           be;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_be;
    logic                 unused_ok;

    // The burst type is irrelevant: every beat carries its own address.
    assign unused_ok = ^bus.HBURST;

    always_comb begin
        accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY &
                 ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));

        req_err = (|(bus.HADDR >> (ADDR_BITS + 2))) |
                  (bus.HSIZE > 3'd2) |
                  ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                  ((bus.HSIZE == 3'd2) & (|bus.HADDR[1:0]));

        if (!accept) begin
            beat_state = ST_IDLE;
        end else if (req_err) begin
            beat_state = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
            beat_state = ST_WAIT;
        end else begin
            beat_state = ST_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
`ifdef AHB_SRAM_ZERO_INIT_EN
        clr_d   = clr_q;
`endif

        if (accept) begin
            addr_d  = bus.HADDR[ADDR_BITS+1:0];
            size_d  = bus.HSIZE[1:0];
            write_d = bus.HWRITE & ~req_err;
        end

        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = beat_state;
                cnt_d   = 4'd0;
            end
            ST_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SRAM_ZERO_INIT_EN
            ST_CLEAR: begin
                clr_d = clr_q + CLR_ONE;
                if (clr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= RESET_STATE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
`ifdef AHB_SRAM_ZERO_INIT_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
`ifdef AHB_SRAM_ZERO_INIT_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Lane enables follow little-endian byte placement within the word.
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase

        wr_en   = (state_q == ST_DATA) & write_q;
        wr_idx  = addr_q[ADDR_BITS+1:2];
        wr_data = bus.HWDATA;
        wr_be   = be;
`ifdef AHB_SRAM_ZERO_INIT_EN
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_q;
            wr_data = '0;
            wr_be   = 4'b1111;
        end
`endif
    end

    // Memory is not reset; a reset cycle only suppresses the pending commit.
    always_ff @(posedge HCLK) begin
        if (HRESETn && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1) || (state_q == ST_CLEAR));
        bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        bus.HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_q[addr_q[ADDR_BITS+1:2]] : 32'h0;
    end

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// tb/tb_ahb_lite_sram_responder.sv - directed bench for ahb_lite_sram_responder with 0 and 2 wait states
module tb_ahb_lite_sram_responder;

    logic        clk;
    logic        rstn;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        sel0, sel2;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_lite_sram_responder_if if0 ();
    ahb_lite_sram_responder_if if2 ();

    assign if0.HADDR  = haddr;
    assign if0.HBURST = hburst;
    assign if0.HSEL   = sel0;
    assign if0.HSIZE  = hsize;
    assign if0.HTRANS = htrans;
    assign if0.HWDATA = hwdata;
    assign if0.HWRITE = hwrite;
    assign if0.HREADY = if0.HREADYOUT;

    assign if2.HADDR  = haddr;
    assign if2.HBURST = hburst;
    assign if2.HSEL   = sel2;
    assign if2.HSIZE  = hsize;
    assign if2.HTRANS = htrans;
    assign if2.HWDATA = hwdata;
    assign if2.HWRITE = hwrite;
    assign if2.HREADY = if2.HREADYOUT;

    ahb_lite_sram_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut0 (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (if0.slave)
    );

    ahb_lite_sram_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u_dut2 (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 2) ? if2.HREADYOUT : if0.HREADYOUT;
    endfunction

    function automatic logic rsp(input int w);
        return (w == 2) ? if2.HRESP : if0.HRESP;
    endfunction

    function automatic logic [31:0] rdat(input int w);
        return (w == 2) ? if2.HRDATA : if0.HRDATA;
    endfunction

    // Single non-pipelined transfer; returns at the negedge of the final data-phase cycle.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int waits,
                        output logic resp_first, output logic resp_last);
        int guard;
        @(posedge clk); #1;
        haddr  = addr;
        hsize  = size;
        hwrite = wr;
        htrans = 2'b10;
        sel0   = (which == 0);
        sel2   = (which == 2);
        @(posedge clk); #1;
        htrans = 2'b00;
        sel0   = 1'b0;
        sel2   = 1'b0;
        hwdata = wdata;
        waits  = 0;
        guard  = 0;
        @(negedge clk);
        resp_first = rsp(which);
        while (!rdy(which) && guard < 40) begin
            waits++;
            guard++;
            @(negedge clk);
        end
        chk("xfer_done", 32'(rdy(which)), 32'd1);
        rdata     = rdat(which);
        resp_last = rsp(which);
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!(if0.HREADYOUT && if2.HREADYOUT) && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        chk("ready_after_reset", 32'(if0.HREADYOUT & if2.HREADYOUT), 32'd1);
    endtask

    logic [31:0] rd;
    int          w;
    logic        rf, rl;
    int          low_cnt;
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    logic [31:0] ra [4];
    logic [31:0] re [4];
    logic [31:0] exp_keep;

    initial begin
        rstn = 1'b0; haddr = '0; hwdata = '0; hsize = 3'd2; hburst = 3'd0;
        htrans = 2'b00; hwrite = 1'b0; sel0 = 1'b0; sel2 = 1'b0;
        wa = '{32'h38, 32'h3C, 32'h30, 32'h34};
        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        ra = '{32'h30, 32'h34, 32'h38, 32'h3C};
        re = '{32'd3, 32'd4, 32'd1, 32'd2};

        repeat (3) @(negedge clk);
`ifdef AHB_SRAM_ZERO_INIT_EN
        chk("rst_hreadyout", 32'(if0.HREADYOUT), 32'd0);
`else
        chk("rst_hreadyout", 32'(if0.HREADYOUT), 32'd1);
`endif
        chk("rst_hresp", 32'(if0.HRESP), 32'd0);
        chk("rst_hrdata", if0.HRDATA, 32'h0);
        chk("rst_hresp_ws2", 32'(if2.HRESP), 32'd0);

        rstn = 1'b1;
        low_cnt = 0;
        while (!if0.HREADYOUT && low_cnt < 400) begin
            low_cnt++;
            @(negedge clk);
        end
`ifdef AHB_SRAM_ZERO_INIT_EN
        chk("sweep_len", 32'(low_cnt), 32'd256);
        wait_ready();
        xfer(0, 1'b0, 32'h3FC, 3'd2, 32'h0, rd, w, rf, rl);
        chk("sweep_zero", rd, 32'h0);
`else
        chk("no_sweep_len", 32'(low_cnt), 32'd0);
`endif

        // Word write/read, zero wait states
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h12345678, rd, w, rf, rl);
        chk("word_wr_waits", 32'(w), 32'd0);
        chk("word_wr_resp", 32'(rl), 32'd0);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, rl);
        chk("word_rd_data", rd, 32'h12345678);
        chk("word_rd_waits", 32'(w), 32'd0);
        chk("word_rd_resp", 32'(rl), 32'd0);
        @(negedge clk);
        chk("idle_hrdata", if0.HRDATA, 32'h0);

        // Byte and halfword lanes
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h00000000, rd, w, rf, rl);
        xfer(0, 1'b1, 32'h21, 3'd0, 32'hAAAAAAAA, rd, w, rf, rl);
        xfer(0, 1'b1, 32'h22, 3'd1, 32'hBEEFBEEF, rd, w, rf, rl);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, w, rf, rl);
        chk("lanes_rd", rd, 32'hBEEFAA00);

        // Error responses
        xfer(0, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd, w, rf, rl);
        xfer(0, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, rd, w, rf, rl);
        chk("err_range_waits", 32'(w), 32'd1);
        chk("err_range_resp1", 32'(rf), 32'd1);
        chk("err_range_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b1, 32'h02, 3'd2, 32'h00000000, rd, w, rf, rl);
        chk("err_align_waits", 32'(w), 32'd1);
        chk("err_align_resp1", 32'(rf), 32'd1);
        chk("err_align_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b1, 32'h01, 3'd1, 32'h00000000, rd, w, rf, rl);
        chk("err_half_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b1, 32'h00, 3'd3, 32'h00000000, rd, w, rf, rl);
        chk("err_size_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, w, rf, rl);
        chk("err_no_modify", rd, 32'hCAFEF00D);
        chk("err_after_okay", 32'(rl), 32'd0);

        // WRAP4 burst, fully pipelined
        @(posedge clk); #1;
        sel0 = 1'b1; hwrite = 1'b1; hsize = 3'd2; hburst = 3'b010; htrans = 2'b10; haddr = wa[0];
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            hwdata = wd[i-1];
            if (i < 4) begin
                haddr = wa[i]; htrans = 2'b11;
            end else begin
                htrans = 2'b00; sel0 = 1'b0;
            end
            @(negedge clk);
            chk("burst_wr_rdy", 32'(if0.HREADYOUT), 32'd1);
        end
        @(posedge clk); #1;
        sel0 = 1'b1; hwrite = 1'b0; hburst = 3'b011; htrans = 2'b10; haddr = ra[0];
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                haddr = ra[i]; htrans = 2'b11;
            end else begin
                htrans = 2'b00; sel0 = 1'b0;
            end
            @(negedge clk);
            chk("burst_rd_data", if0.HRDATA, re[i-1]);
        end
        hburst = 3'd0;

        // Two wait states, then a pipelined NONSEQ
        xfer(2, 1'b1, 32'h80, 3'd2, 32'h55AA33CC, rd, w, rf, rl);
        chk("ws2_wr_waits", 32'(w), 32'd2);
        xfer(2, 1'b1, 32'h84, 3'd2, 32'h01020304, rd, w, rf, rl);
        xfer(2, 1'b0, 32'h80, 3'd2, 32'h0, rd, w, rf, rl);
        chk("ws2_rd_waits", 32'(w), 32'd2);
        chk("ws2_rd_data", rd, 32'h55AA33CC);
        @(posedge clk); #1;
        sel2 = 1'b1; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10; haddr = 32'h80;
        @(posedge clk); #1;
        haddr = 32'h84;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("pipe_rdy", 32'(if2.HREADYOUT), (c == 2 || c == 5) ? 32'd1 : 32'd0);
            if (c == 2) chk("pipe_rd_a", if2.HRDATA, 32'h55AA33CC);
            if (c == 5) chk("pipe_rd_b", if2.HRDATA, 32'h01020304);
            if (c == 2) begin
                @(posedge clk); #1;
                htrans = 2'b00; sel2 = 1'b0;
            end
        end

        // Reset during the wait phase of a write
        xfer(2, 1'b1, 32'h40, 3'd2, 32'h11111111, rd, w, rf, rl);
        @(posedge clk); #1;
        sel2 = 1'b1; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; haddr = 32'h40;
        @(posedge clk); #1;
        htrans = 2'b00; sel2 = 1'b0; hwdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstmid_in_wait", 32'(if2.HREADYOUT), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
`ifndef AHB_SRAM_ZERO_INIT_EN
        chk("rstmid_hreadyout", 32'(if2.HREADYOUT), 32'd1);
`endif
        chk("rstmid_hresp", 32'(if2.HRESP), 32'd0);
        chk("rstmid_hrdata", if2.HRDATA, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wait_ready();
        xfer(2, 1'b0, 32'h40, 3'd2, 32'h0, rd, w, rf, rl);
`ifdef AHB_SRAM_ZERO_INIT_EN
        exp_keep = 32'h0;
`else
        exp_keep = 32'h11111111;
`endif
        chk("rstmid_no_commit", rd, exp_keep);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
